// File: rtl/cook_timer_pkg.sv
// Shared types, constants and time-arithmetic helpers for the cook timer.
package cook_timer_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StRun   = 3'd1,
      StPause = 3'd2,
      StDone  = 3'd3
   } state_e;

   localparam logic [5:0] MAX_MIN  = 6'd59;
   localparam logic [5:0] MAX_SEC  = 6'd59;
   localparam logic [5:0] SEC_STEP = 6'd10;

   typedef struct packed {
      logic [5:0] mins;
      logic [5:0] secs;
   } cook_time_t;

   // +1 minute, saturating at MAX_MIN; seconds untouched.
   function automatic cook_time_t add_min(input cook_time_t t);
      cook_time_t r;
      r = t;
      if (t.mins < MAX_MIN) begin
         r.mins = t.mins + 6'd1;
      end
      return r;
   endfunction

   // +SEC_STEP seconds with carry into minutes; a carry past MAX_MIN pins to 59:59.
   function automatic cook_time_t add_sec(input cook_time_t t);
      cook_time_t r;
      logic [6:0] s;
      r = t;
      s = {1'b0, t.secs} + {1'b0, SEC_STEP};
      if (s > {1'b0, MAX_SEC}) begin
         if (t.mins >= MAX_MIN) begin
            r.mins = MAX_MIN;
            r.secs = MAX_SEC;
         end else begin
            r.mins = t.mins + 6'd1;
            r.secs = 6'(s - 7'd60);
         end
      end else begin
         r.secs = s[5:0];
      end
      return r;
   endfunction

   // One-second countdown step with borrow from minutes; 00:00 stays 00:00.
   function automatic cook_time_t dec_time(input cook_time_t t);
      cook_time_t r;
      r = t;
      if (t.secs != 6'd0) begin
         r.secs = t.secs - 6'd1;
      end else if (t.mins != 6'd0) begin
         r.mins = t.mins - 6'd1;
         r.secs = MAX_SEC;
      end
      return r;
   endfunction

endpackage

// File: rtl/cook_tick_gen.sv
// Half-second divider: one-cycle tick every CLK_HZ/2 enabled cycles.
module cook_tick_gen #(
   parameter int unsigned CLK_HZ = 100_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);

   localparam int unsigned HALF = CLK_HZ / 2;
   localparam int unsigned CW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] LAST = CW'(HALF - 1);

   logic [CW-1:0] r_cnt;

   // Tick is not gated by clear: the tick that causes a state change must still be seen.
   assign o_tick = i_en && (r_cnt == LAST);

   // Divider counter: synchronous clear wins, otherwise counts only while enabled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= o_tick ? '0 : r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/cook_timer_ctrl.sv
// Microwave cook-time sequencer: button handling, mm:ss countdown and display control.
module cook_timer_ctrl
   import cook_timer_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 100_000_000,
   parameter int unsigned QUICK_SEC = 30,
   parameter int unsigned DONE_SEC  = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_btn_min,
   input  logic       i_btn_sec,
   input  logic       i_btn_start,
   input  logic       i_btn_cancel,
   input  logic       i_door_open,
   output logic [5:0] o_sec,
   output logic [5:0] o_min,
   output logic       o_blank,
   output logic       o_cook_en,
   output logic       o_done,
   output logic [2:0] o_state
);

   localparam cook_time_t QUICK_TIME = {6'(QUICK_SEC / 60), 6'(QUICK_SEC % 60)};
   localparam logic [7:0] DONE_LAST  = 8'(DONE_SEC - 1);

   state_e     r_state, w_state_d;
   cook_time_t r_time, w_time_d, w_dec;
   logic [7:0] r_done_cnt, w_done_cnt_d;
   logic       r_blank, w_blank_d;
   logic       r_cook_en, r_done, r_phase, r_door;
   logic       w_tick, w_sec_evt, w_tick_en, w_tick_clr;
   logic       w_start_ok, w_door_rise, w_any_btn;

   assign w_start_ok  = i_btn_start & ~i_door_open;
   assign w_door_rise = i_door_open & ~r_door;
   assign w_any_btn   = i_btn_min | i_btn_sec | i_btn_cancel | w_start_ok;
   assign w_sec_evt   = w_tick & r_phase;
   assign w_dec       = dec_time(r_time);

   // Divider runs in RUN and DONE only, so PAUSE preserves the partial second.
   assign w_tick_en  = (r_state == StRun) || (r_state == StDone);
   assign w_tick_clr = ((r_state == StIdle) && (w_state_d == StRun)) ||
                       ((r_state != StDone) && (w_state_d == StDone));

   cook_tick_gen #(
      .CLK_HZ (CLK_HZ)
   ) u_tick_gen (
      .clk    (clk),
      .reset  (reset),
      .i_en   (w_tick_en),
      .i_clr  (w_tick_clr),
      .o_tick (w_tick)
   );

   // Next-state and next-time logic with button priority cancel > start > min > sec.
   always_comb begin
      w_state_d    = r_state;
      w_time_d     = r_time;
      w_blank_d    = 1'b0;
      w_done_cnt_d = r_done_cnt;
      unique case (r_state)
         StIdle: begin
            if (i_btn_cancel) begin
               w_time_d = '0;
            end else if (w_start_ok) begin
               w_state_d = StRun;
               if (r_time == '0) begin
                  w_time_d = QUICK_TIME;
               end
            end else if (i_btn_min) begin
               w_time_d = add_min(r_time);
            end else if (i_btn_sec) begin
               w_time_d = add_sec(r_time);
            end
         end
         StRun: begin
            if (i_door_open || i_btn_cancel) begin
               w_state_d = StPause;
            end else begin
               if (w_sec_evt) begin
                  w_time_d = w_dec;
               end
               // Reaching 00:00 ends the cook even if time is added in the same cycle.
               if (w_sec_evt && (w_dec == '0)) begin
                  w_state_d    = StDone;
                  w_time_d     = '0;
                  w_done_cnt_d = '0;
               end else if (!i_btn_start && i_btn_min) begin
                  w_time_d = add_min(w_time_d);
               end else if (!i_btn_start && i_btn_sec) begin
                  w_time_d = add_sec(w_time_d);
               end
            end
         end
         StPause: begin
            w_blank_d = w_tick ? ~r_blank : r_blank;
            if (i_btn_cancel) begin
               w_state_d = StIdle;
               w_time_d  = '0;
               w_blank_d = 1'b0;
            end else if (w_start_ok) begin
               w_state_d = StRun;
               w_blank_d = 1'b0;
            end else if (i_btn_min) begin
               w_time_d = add_min(r_time);
            end else if (i_btn_sec) begin
               w_time_d = add_sec(r_time);
            end
         end
         StDone: begin
            w_time_d = '0;
            if (w_any_btn || w_door_rise) begin
               w_state_d = StIdle;
            end else if (w_sec_evt && (r_done_cnt == DONE_LAST)) begin
               w_state_d = StIdle;
            end else begin
               w_blank_d = w_tick ? ~r_blank : r_blank;
               if (w_sec_evt) begin
                  w_done_cnt_d = r_done_cnt + 8'd1;
               end
            end
         end
         default: begin
            w_state_d = StIdle;
            w_time_d  = '0;
         end
      endcase
   end

   // State, time and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= StIdle;
         r_time     <= '0;
         r_blank    <= 1'b0;
         r_done_cnt <= '0;
         r_cook_en  <= 1'b0;
         r_done     <= 1'b0;
         r_door     <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_time     <= w_time_d;
         r_blank    <= w_blank_d;
         r_done_cnt <= w_done_cnt_d;
         r_cook_en  <= (w_state_d == StRun);
         r_done     <= (w_state_d == StDone);
         r_door     <= i_door_open;
      end
   end

   // Phase bit: every second tick is a one-second event; restarts with the divider.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_phase <= 1'b0;
      end else if (w_tick_clr) begin
         r_phase <= 1'b0;
      end else if (w_tick) begin
         r_phase <= ~r_phase;
      end
   end

   assign o_sec     = r_time.secs;
   assign o_min     = r_time.mins;
   assign o_blank   = r_blank;
   assign o_cook_en = r_cook_en;
   assign o_done    = r_done;
   assign o_state   = r_state;

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Directed bench for cook_timer_ctrl with a 10-cycle tick (CLK_HZ = 20).
module tb_cook_timer_ctrl;

   logic       clk;
   logic       reset;
   logic       btn_min, btn_sec, btn_start, btn_cancel, door_open;
   logic [5:0] sec, min;
   logic       blank, cook_en, done;
   logic [2:0] state;

   int n_checks;
   int n_errors;

   cook_timer_ctrl #(
      .CLK_HZ    (20),
      .QUICK_SEC (30),
      .DONE_SEC  (3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .i_btn_min    (btn_min),
      .i_btn_sec    (btn_sec),
      .i_btn_start  (btn_start),
      .i_btn_cancel (btn_cancel),
      .i_door_open  (door_open),
      .o_sec        (sec),
      .o_min        (min),
      .o_blank      (blank),
      .o_cook_en    (cook_en),
      .o_done       (done),
      .o_state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance n clock edges and settle 1 ns past the last one.
   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One-cycle pulse, b = {cancel, start, min, sec}; returns 1 ns after the acting edge.
   task automatic pulse(input logic [3:0] b);
      {btn_cancel, btn_start, btn_min, btn_sec} = b;
      @(posedge clk);
      #1;
      {btn_cancel, btn_start, btn_min, btn_sec} = 4'b0000;
   endtask

   task automatic check_time(input string tag, input int m, input int s);
      check_eq({tag, ".min"}, 32'(min), m);
      check_eq({tag, ".sec"}, 32'(sec), s);
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      reset     = 1'b1;
      {btn_cancel, btn_start, btn_min, btn_sec} = 4'b0000;
      door_open = 1'b0;
      wait_cyc(2);
      check_eq("rst.state", 32'(state), 0);
      check_time("rst", 0, 0);
      check_eq("rst.cook_en", 32'(cook_en), 0);
      check_eq("rst.done", 32'(done), 0);
      check_eq("rst.blank", 32'(blank), 0);
      reset = 1'b0;
      wait_cyc(1);

      // Set 01:20 and start.
      pulse(4'b0001);
      check_time("set10", 0, 10);
      pulse(4'b0001);
      pulse(4'b0010);
      check_time("set120", 1, 20);
      pulse(4'b0100);
      check_eq("start.state", 32'(state), 1);
      check_eq("start.cook_en", 32'(cook_en), 1);
      check_time("start", 1, 20);
      wait_cyc(19);
      check_time("pre_sec", 1, 20);
      wait_cyc(1);
      check_time("first_sec", 1, 19);
      wait_cyc(400);
      check_time("plus20", 0, 59);
      pulse(4'b1000);
      check_eq("cancel_run.state", 32'(state), 2);
      check_eq("cancel_run.cook_en", 32'(cook_en), 0);
      check_time("cancel_run", 0, 59);
      pulse(4'b1000);
      check_eq("cancel_pause.state", 32'(state), 0);
      check_time("cancel_pause", 0, 0);

      // Quick start, run down to DONE, blink, auto return.
      pulse(4'b0100);
      check_eq("quick.state", 32'(state), 1);
      check_time("quick", 0, 30);
      wait_cyc(599);
      check_eq("last_sec.state", 32'(state), 1);
      check_time("last_sec", 0, 1);
      wait_cyc(1);
      check_eq("done.state", 32'(state), 3);
      check_eq("done.done", 32'(done), 1);
      check_eq("done.cook_en", 32'(cook_en), 0);
      check_time("done", 0, 0);
      check_eq("done.blank0", 32'(blank), 0);
      wait_cyc(9);
      check_eq("done.blank9", 32'(blank), 0);
      wait_cyc(1);
      check_eq("done.blank10", 32'(blank), 1);
      wait_cyc(10);
      check_eq("done.blank20", 32'(blank), 0);
      wait_cyc(39);
      check_eq("done59.state", 32'(state), 3);
      wait_cyc(1);
      check_eq("done60.state", 32'(state), 0);
      check_eq("done60.done", 32'(done), 0);
      check_eq("done60.blank", 32'(blank), 0);

      // Door pause at 00:45 mid-second, blocked start, resume keeps partial second.
      pulse(4'b0010);
      pulse(4'b0100);
      wait_cyc(300);
      check_time("at45", 0, 45);
      wait_cyc(15);
      door_open = 1'b1;
      wait_cyc(1);
      check_eq("door.state", 32'(state), 2);
      check_eq("door.cook_en", 32'(cook_en), 0);
      wait_cyc(30);
      check_time("door_frozen", 0, 45);
      check_eq("door.blank", 32'(blank), 0);
      pulse(4'b0100);
      check_eq("door_start.state", 32'(state), 2);
      door_open = 1'b0;
      wait_cyc(1);
      pulse(4'b0100);
      check_eq("resume.state", 32'(state), 1);
      check_eq("resume.cook_en", 32'(cook_en), 1);
      wait_cyc(3);
      check_time("resume3", 0, 45);
      wait_cyc(1);
      check_time("resume4", 0, 44);

      // Cancel beats start in the same cycle.
      pulse(4'b1100);
      check_eq("cancel_start.state", 32'(state), 2);
      check_eq("cancel_start.cook_en", 32'(cook_en), 0);
      pulse(4'b1000);
      check_eq("clear.state", 32'(state), 0);
      check_time("clear", 0, 0);

      // Carry and saturation.
      repeat (5) pulse(4'b0001);
      check_time("sec50", 0, 50);
      pulse(4'b0001);
      check_time("carry", 1, 0);
      repeat (58) pulse(4'b0010);
      check_time("min59", 59, 0);
      pulse(4'b0010);
      check_time("min_sat", 59, 0);
      pulse(4'b0100);
      wait_cyc(100);
      check_time("run5", 58, 55);
      pulse(4'b0010);
      check_time("run_addmin", 59, 55);
      pulse(4'b0001);
      check_time("sat5959", 59, 59);
      pulse(4'b0010);
      check_time("sat_min", 59, 59);
      pulse(4'b1000);
      pulse(4'b1000);
      check_time("clear2", 0, 0);

      // Asynchronous reset mid-countdown at 00:10.
      pulse(4'b0001);
      pulse(4'b0100);
      check_time("rst_run", 0, 10);
      wait_cyc(5);
      #3;
      reset = 1'b1;
      #1;
      check_eq("arst.state", 32'(state), 0);
      check_time("arst", 0, 0);
      check_eq("arst.cook_en", 32'(cook_en), 0);
      wait_cyc(2);
      reset = 1'b0;
      wait_cyc(3);
      check_eq("post_rst.state", 32'(state), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
